// File: rtl/pipelined_subtractor_if.sv
// Operand/result handshake bundle for pipelined_subtractor.
// The slave modport is the subtractor; the master modport is whoever feeds operands
// and drains results.
interface pipelined_subtractor_if #(
   parameter int unsigned WIDTH = 37
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   minuend;
   logic [WIDTH-1:0] subtrahend;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   diff;
   logic             borrow;

   modport slave (
      input  in_valid,
      input  minuend,
      input  subtrahend,
      input  out_ready,
      output in_ready,
      output out_valid,
      output diff,
      output borrow
   );

   modport master (
      output in_valid,
      output minuend,
      output subtrahend,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  diff,
      input  borrow
   );

endinterface

// File: rtl/pipelined_subtractor.sv
// Pipelined (WIDTH+1)-bit subtractor: diff = minuend - subtrahend, borrow = subtrahend > minuend.
// The borrow chain is cut into SEG_WIDTH-bit segments, one segment resolved per stage.
// Stage 0 registers the operands; stage k (1..NSEG) resolves segment k-1, so a result
// appears NSEG+1 cycles after it is accepted. A single global advance signal moves or
// freezes the whole pipe, so bubbles are kept during a stall.
// Optional build macro SUBTRACTOR_SATURATE_EN: a borrowing result is forced to diff = 0 at
// the output stage (borrow still reported).
module pipelined_subtractor #(
   parameter int unsigned WIDTH     = 37,
   parameter int unsigned SEG_WIDTH = 8
) (
   input logic                   clk,
   input logic                   reset,
   pipelined_subtractor_if.slave bus
);

   localparam int unsigned W1   = WIDTH + 1;
   localparam int unsigned NSEG = (W1 + SEG_WIDTH - 1) / SEG_WIDTH;

   // Per-stage state. a_q holds resolved diff bits below the stage's segment boundary and
   // still-unresolved minuend bits above it; b_q is the zero-extended subtrahend.
   logic [NSEG:0]   valid_q, valid_d;
   logic [W1-1:0]   a_q   [NSEG+1];
   logic [W1-1:0]   a_d   [NSEG+1];
   logic [W1-1:0]   b_q   [NSEG];
   logic [W1-1:0]   b_d   [NSEG];
   logic [NSEG:0]   bor_q, bor_d;

   // Combinational segment results feeding stages 1..NSEG (index k-1 feeds stage k).
   logic [W1-1:0]   comp_a [NSEG];
   logic [NSEG-1:0] comp_bor;

   logic adv;

   // Whole pipe advances whenever the output slot is empty or being drained.
   assign adv = !valid_q[NSEG] | bus.out_ready;

   for (genvar k = 1; k <= NSEG; k++) begin : g_stage
      localparam int unsigned Lo   = (k - 1) * SEG_WIDTH;
      localparam int unsigned SegW = (Lo + SEG_WIDTH > W1) ? (W1 - Lo) : SEG_WIDTH;

      logic [SegW:0]  res;
      logic [W1-1:0]  nxt_a;

      // Resolve one segment; the extra top bit of res is the borrow-out.
      always_comb begin
         res   = {1'b0, a_q[k-1][Lo +: SegW]}
               - {1'b0, b_q[k-1][Lo +: SegW]}
               - {{SegW{1'b0}}, bor_q[k-1]};
         nxt_a = a_q[k-1];
         nxt_a[Lo +: SegW] = res[SegW-1:0];
      end

      assign comp_a[k-1]   = nxt_a;
      assign comp_bor[k-1] = res[SegW];
   end

   // Next state: hold everything unless the pipe advances, then shift one stage.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      bor_d   = bor_q;
      if (adv) begin
         valid_d[0] = bus.in_valid;
         a_d[0]     = bus.minuend;
         b_d[0]     = {1'b0, bus.subtrahend};
         bor_d[0]   = 1'b0;
         for (int k = 1; k <= NSEG; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = comp_a[k-1];
            bor_d[k]   = comp_bor[k-1];
         end
         for (int k = 1; k < NSEG; k++) begin
            b_d[k] = b_q[k-1];
         end
`ifdef SUBTRACTOR_SATURATE_EN
         if (comp_bor[NSEG-1]) begin
            a_d[NSEG] = '0;
         end
`endif
      end
   end

   // Stage registers; synchronous reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         bor_q   <= '0;
         for (int k = 0; k <= NSEG; k++) begin
            a_q[k] <= '0;
         end
         for (int k = 0; k < NSEG; k++) begin
            b_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         bor_q   <= bor_d;
         for (int k = 0; k <= NSEG; k++) begin
            a_q[k] <= a_d[k];
         end
         for (int k = 0; k < NSEG; k++) begin
            b_q[k] <= b_d[k];
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[NSEG];
   assign bus.diff      = a_q[NSEG];
   assign bus.borrow    = bor_q[NSEG];

endmodule
